sdram_layer2_master: RTL and testbench

SDRAM_LAYER2_MASTER -- requirements
Module: sdram_layer2_master

---
 rtl/sdram_layer2_master.sv | 236 +++++++++++++++++++++++
 tb/tb_sdram_layer2_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_layer2_master.sv
// sdram_layer2_master: second dense layer of a small neural net, run over an
// Avalon-MM SDRAM port. For every output j it streams L1[i] and W2[j][i]
// (one read outstanding at a time) and accumulates a signed 32-bit dot product.
// It then writes acc[23:8] (Q8.8), saturated to 16 bits, to the output area.
// Optional feature macro: L2_ARGMAX_EN. When it is defined, the block tracks
// the largest written value and reports its index on result. When it is
// undefined, result is tied to 0.
module sdram_layer2_master #(
    parameter int L1_OFST = 200000,
    parameter int W2_OFST = 500000,
    parameter int L2_OFST = 600000,
    parameter int HIDDEN  = 200,
    parameter int OUTPUTS = 10
) (
    input  logic        clk,
    input  logic        reset,
    output logic        read_n,
    output logic        write_n,
    output logic        chipselect,
    output logic [1:0]  byteenable,
    output logic [31:0] address,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [15:0] readdata,
    output logic [15:0] writedata,
    input  logic        ready,
    output logic        done,
    output logic [3:0]  state,
    output logic [3:0]  result
);
    // Bus handshake: a request (read_n=0 or write_n=0) keeps its address and
    // data stable until waitrequest=0 is sampled on a rising edge. The strobe
    // drops on the following cycle. Read data is accepted only while a read
    // is outstanding, that is, after the request was taken and before
    // readdatavalid arrives.
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RD_L1 = 4'd1,
        S_RD_W2 = 4'd2,
        S_MAC   = 4'd3,
        S_WRITE = 4'd4,
        S_DONE  = 4'd5,
        S_NEXT  = 4'd6
    } state_t;

    state_t             state_q;
    logic               read_n_q;
    logic               write_n_q;
    logic [31:0]        address_q;
    logic [15:0]        writedata_q;
    logic               done_q;
    logic               rd_wait_q;   // read accepted by the slave, data pending
    logic [15:0]        i_q;
    logic [15:0]        j_q;
    logic signed [31:0] acc_q;
    logic signed [15:0] a_q;
    logic signed [15:0] w_q;

    logic signed [31:0] prod_d;
    logic signed [31:0] acc_d;

    function automatic logic [31:0] l1_addr(input logic [15:0] idx);
        return 32'(L1_OFST) + (32'(idx) << 1);
    endfunction

    function automatic logic [31:0] w2_addr(input logic [15:0] row, input logic [15:0] col);
        return 32'(W2_OFST) + ((32'(HIDDEN) * 32'(row) + 32'(col)) << 1);
    endfunction

    function automatic logic [31:0] l2_addr(input logic [15:0] row);
        return 32'(L2_OFST) + (32'(row) << 1);
    endfunction

    // Take the Q8.8 slice acc[23:8]. It fits in 16 bits only when acc[31:23]
    // is a pure sign extension. Otherwise clamp toward the sign of acc.
    function automatic logic [15:0] sat16(input logic [31:0] v);
        if (v[31:23] == {9{v[31]}}) return v[23:8];
        else if (v[31])             return 16'h8000;
        else                        return 16'h7FFF;
    endfunction

    // Signed 16x16 product and the wrapping accumulate used by MAC.
    always_comb begin
        prod_d = a_q * w_q;
        acc_d  = acc_q + prod_d;
    end

`ifdef L2_ARGMAX_EN
    logic signed [15:0] max_q;
    logic [3:0]         idx_q;
    logic [3:0]         result_q;
    logic               upd_d;

    // Row 0 always loads. Later rows win only when strictly greater, so the
    // lowest j wins a tie.
    always_comb begin
        upd_d = (j_q == 16'd0) || ($signed(writedata_q) > max_q);
    end
`endif

    // Main sequencer. All bus outputs are registered and updated with the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            read_n_q    <= 1'b1;
            write_n_q   <= 1'b1;
            address_q   <= '0;
            writedata_q <= '0;
            done_q      <= 1'b0;
            rd_wait_q   <= 1'b0;
            i_q         <= '0;
            j_q         <= '0;
            acc_q       <= '0;
            a_q         <= '0;
            w_q         <= '0;
`ifdef L2_ARGMAX_EN
            max_q       <= '0;
            idx_q       <= '0;
            result_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    i_q       <= '0;
                    j_q       <= '0;
                    acc_q     <= '0;
                    done_q    <= 1'b0;
                    read_n_q  <= 1'b1;
                    write_n_q <= 1'b1;
                    if (ready) begin
                        state_q   <= S_RD_L1;
                        read_n_q  <= 1'b0;
                        rd_wait_q <= 1'b0;
                        address_q <= l1_addr(16'd0);
                    end
                end
                S_RD_L1: begin
                    if (!rd_wait_q) begin
                        if (!waitrequest) begin
                            read_n_q  <= 1'b1;
                            rd_wait_q <= 1'b1;
                        end
                    end else if (readdatavalid) begin
                        a_q       <= readdata;
                        state_q   <= S_RD_W2;
                        read_n_q  <= 1'b0;
                        rd_wait_q <= 1'b0;
                        address_q <= w2_addr(j_q, i_q);
                    end
                end
                S_RD_W2: begin
                    if (!rd_wait_q) begin
                        if (!waitrequest) begin
                            read_n_q  <= 1'b1;
                            rd_wait_q <= 1'b1;
                        end
                    end else if (readdatavalid) begin
                        w_q       <= readdata;
                        state_q   <= S_MAC;
                        rd_wait_q <= 1'b0;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_d;
                    if (i_q < 16'(HIDDEN - 1)) begin
                        i_q       <= i_q + 16'd1;
                        state_q   <= S_RD_L1;
                        read_n_q  <= 1'b0;
                        address_q <= l1_addr(i_q + 16'd1);
                    end else begin
                        state_q     <= S_WRITE;
                        write_n_q   <= 1'b0;
                        address_q   <= l2_addr(j_q);
                        writedata_q <= sat16(acc_d);
                    end
                end
                S_WRITE: begin
                    if (!waitrequest) begin
                        write_n_q <= 1'b1;
`ifdef L2_ARGMAX_EN
                        if (upd_d) begin
                            max_q <= $signed(writedata_q);
                            idx_q <= j_q[3:0];
                        end
`endif
                        if (j_q < 16'(OUTPUTS - 1)) begin
                            state_q <= S_NEXT;
                        end else begin
                            state_q     <= S_DONE;
                            done_q      <= 1'b1;
                            address_q   <= '0;
                            writedata_q <= '0;
`ifdef L2_ARGMAX_EN
                            result_q    <= upd_d ? j_q[3:0] : idx_q;
`endif
                        end
                    end
                end
                S_NEXT: begin
                    i_q       <= '0;
                    acc_q     <= '0;
                    j_q       <= j_q + 16'd1;
                    state_q   <= S_RD_L1;
                    read_n_q  <= 1'b0;
                    rd_wait_q <= 1'b0;
                    address_q <= l1_addr(16'd0);
                end
                S_DONE: begin
                    done_q    <= 1'b1;
                    read_n_q  <= 1'b1;
                    write_n_q <= 1'b1;
                    if (!ready) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign read_n     = read_n_q;
    assign write_n    = write_n_q;
    assign chipselect = 1'b1;
    assign byteenable = 2'b11;
    assign address    = address_q;
    assign writedata  = writedata_q;
    assign done       = done_q;
    assign state      = state_q;
`ifdef L2_ARGMAX_EN
    assign result     = result_q;
`else
    assign result     = 4'd0;
`endif

endmodule

// File: tb/tb_sdram_layer2_master.sv
// Bench for sdram_layer2_master with HIDDEN=4 and OUTPUTS=3. The memory model
// answers reads after a 2-cycle readdatavalid latency. It can optionally stall
// every request for 5 cycles. Each expected output write is queued before a
// job starts, and a write monitor pops and compares the queue on each write.
module tb_sdram_layer2_master;
    localparam int HID  = 4;
    localparam int OUTS = 3;
    localparam int L1O  = 200000;
    localparam int W2O  = 500000;
    localparam int L2O  = 600000;
`ifdef L2_ARGMAX_EN
    localparam bit ARGMAX = 1'b1;
`else
    localparam bit ARGMAX = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        read_n, write_n, chipselect;
    logic [1:0]  byteenable;
    logic [31:0] address;
    logic        waitrequest;
    logic        readdatavalid = 1'b0;
    logic [15:0] readdata = 16'h0;
    logic [15:0] writedata;
    logic        ready;
    logic        done;
    logic [3:0]  state;
    logic [3:0]  result;

    int n_tests = 0;
    int n_fail  = 0;

    logic [47:0] exp_q[$];
    logic [15:0] l1_mem[HID];
    logic [15:0] w2_mem[HID*OUTS];

    logic        stall_en = 1'b0;
    int          wait_cnt = 0;
    logic        req;
    logic        rv_s1 = 1'b0;
    logic [15:0] rd_s1 = 16'h0;
    logic        hold_chk = 1'b0;
    logic [31:0] hold_addr = '0;
    logic        hold_rd = 1'b1;
    logic        hold_wr = 1'b1;

    // Clock and reset block.
    always #5 clk = ~clk;

    sdram_layer2_master #(
        .L1_OFST(L1O), .W2_OFST(W2O), .L2_OFST(L2O), .HIDDEN(HID), .OUTPUTS(OUTS)
    ) dut (
        .clk(clk), .reset(reset), .read_n(read_n), .write_n(write_n),
        .chipselect(chipselect), .byteenable(byteenable), .address(address),
        .waitrequest(waitrequest), .readdatavalid(readdatavalid), .readdata(readdata),
        .writedata(writedata), .ready(ready), .done(done), .state(state), .result(result)
    );

    assign req         = !read_n || !write_n;
    assign waitrequest = stall_en && req && (wait_cnt < 5);

    // Memory model. It decodes read addresses, adds 2 cycles of data latency,
    // and counts stall cycles.
    always @(posedge clk) begin
        if (req && waitrequest) wait_cnt <= wait_cnt + 1;
        else                    wait_cnt <= 0;
        hold_chk  <= req && waitrequest;
        hold_addr <= address;
        hold_rd   <= read_n;
        hold_wr   <= write_n;
        rv_s1     <= 1'b0;
        if (!read_n && !waitrequest) begin
            rv_s1 <= 1'b1;
            n_tests++;
            if (address >= 32'(L1O) && address < 32'(L1O + 2*HID) && !address[0]) begin
                rd_s1 <= l1_mem[int'((address - 32'(L1O)) >> 1)];
            end else if (address >= 32'(W2O) && address < 32'(W2O + 2*HID*OUTS) && !address[0]) begin
                rd_s1 <= w2_mem[int'((address - 32'(W2O)) >> 1)];
            end else begin
                n_fail++;
                $display("FAIL rd_addr: got %0d, required an L1/W2 word address", address);
                rd_s1 <= 16'hDEAD;
            end
        end
        readdatavalid <= rv_s1;
        readdata      <= rd_s1;
    end

    // Write monitor. It pops the expected queue on each write that is accepted
    // at the next edge.
    always @(negedge clk) begin
        if (!write_n && !waitrequest && !reset) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected: got addr=%0d data=%h, required no write", address, writedata);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if ({address, writedata} !== e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             address, writedata, e[47:16], e[15:0]);
                end
            end
        end
    end

    // Stall monitor. While waitrequest holds a request, its strobe and
    // address must not change.
    always @(negedge clk) begin
        if (hold_chk && !reset) begin
            n_tests++;
            if ({address, read_n, write_n} !== {hold_addr, hold_rd, hold_wr}) begin
                n_fail++;
                $display("FAIL stall_hold: got addr=%0d rd_n=%b wr_n=%b, required addr=%0d rd_n=%b wr_n=%b",
                         address, read_n, write_n, hold_addr, hold_rd, hold_wr);
            end
        end
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_l1(input logic [15:0] a0, a1, a2, a3);
        l1_mem[0] = a0; l1_mem[1] = a1; l1_mem[2] = a2; l1_mem[3] = a3;
    endtask

    task automatic set_row(input int j, input logic [15:0] b0, b1, b2, b3);
        w2_mem[HID*j+0] = b0; w2_mem[HID*j+1] = b1;
        w2_mem[HID*j+2] = b2; w2_mem[HID*j+3] = b3;
    endtask

    task automatic push_exp(input int j, input logic [15:0] d);
        exp_q.push_back({32'(L2O + 2*j), d});
    endtask

    // The first job: L1 = 1.0 everywhere, rows of 1.0, 2.0 and -1.0, giving
    // sums 4.0, 8.0 and -4.0 in Q8.8.
    task automatic load_basic();
        set_l1(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        set_row(0, 16'h0100, 16'h0100, 16'h0100, 16'h0100);
        set_row(1, 16'h0200, 16'h0200, 16'h0200, 16'h0200);
        set_row(2, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
        push_exp(0, 16'h0400);
        push_exp(1, 16'h0800);
        push_exp(2, 16'hFC00);
    endtask

    // Driver: raise ready, optionally drop it mid-job, wait for done, then
    // release the job back to IDLE.
    task automatic run_job(input string name, input bit drop_ready, input logic [3:0] exp_res);
        int k;
        ready = 1'b1;
        if (drop_ready) begin
            repeat (20) @(negedge clk);
            ready = 1'b0;
        end
        for (k = 0; k < 4000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check({name, "_done"}, 48'(done), 48'd1);
        check({name, "_result"}, 48'(result), 48'(exp_res));
        ready = 1'b0;
        @(negedge clk);
        check({name, "_idle_state"}, 48'(state), 48'd0);
        check({name, "_idle_done"}, 48'(done), 48'd0);
        check({name, "_writes_left"}, 48'(exp_q.size()), 48'd0);
        exp_q.delete();
    endtask

    initial begin
        int hits;
        reset = 1'b1;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_read_n", 48'(read_n), 48'd1);
        check("rst_write_n", 48'(write_n), 48'd1);
        check("rst_address", 48'(address), 48'd0);
        check("rst_writedata", 48'(writedata), 48'd0);
        check("rst_done", 48'(done), 48'd0);
        check("rst_state", 48'(state), 48'd0);
        check("rst_result", 48'(result), 48'd0);
        check("chipselect", 48'(chipselect), 48'd1);
        check("byteenable", 48'(byteenable), 48'd3);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_no_ready", 48'({read_n, write_n, 4'(state)}), 48'({2'b11, 4'd0}));

        // Basic job. Row 1 holds the maximum.
        load_basic();
        run_job("basic", 1'b0, ARGMAX ? 4'd1 : 4'd0);

        // Positive saturation. Two products of 0x7FFF*0x7FFF sum to 0x7FFE0002,
        // which is still positive in 32 bits (four would wrap). acc[31:23] != 0.
        set_l1(16'h7FFF, 16'h7FFF, 16'h0000, 16'h0000);
        set_row(0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        set_row(1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        set_row(2, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        push_exp(0, 16'h7FFF); push_exp(1, 16'h0000); push_exp(2, 16'h0000);
        run_job("sat_pos", 1'b0, 4'd0);

        // Negative saturation. 2 * (0x8000*0x7FFF) = 0x80010000. Row 1 (0)
        // then beats row 0; row 2 ties row 1 and loses.
        set_row(0, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        push_exp(0, 16'h8000); push_exp(1, 16'h0000); push_exp(2, 16'h0000);
        run_job("sat_neg", 1'b0, ARGMAX ? 4'd1 : 4'd0);

        // Every request stalled for 5 cycles. Same results as the basic job.
        stall_en = 1'b1;
        load_basic();
        run_job("stall", 1'b0, ARGMAX ? 4'd1 : 4'd0);
        stall_en = 1'b0;

        // Reset pulse during the second RD_W2 read request, then a clean restart.
        load_basic();
        ready = 1'b1;
        hits = 0;
        for (int k = 0; k < 2000 && hits < 2; k++) begin
            @(negedge clk);
            if (state == 4'd2 && !read_n) hits++;
        end
        check("rst_mid_found", 48'(hits), 48'd2);
        #1 reset = 1'b1;
        #1;
        check("rst_mid_read_n", 48'(read_n), 48'd1);
        check("rst_mid_state", 48'(state), 48'd0);
        check("rst_mid_addr", 48'(address), 48'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_job("restart", 1'b0, ARGMAX ? 4'd1 : 4'd0);

        // Rows 0 and 2 tie at 3.0 and row 1 is 1.0, so the lowest index wins.
        // ready also drops mid-job.
        set_l1(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        set_row(0, 16'h0100, 16'h0100, 16'h0100, 16'h0000);
        set_row(1, 16'h0100, 16'h0000, 16'h0000, 16'h0000);
        set_row(2, 16'h0100, 16'h0100, 16'h0100, 16'h0000);
        push_exp(0, 16'h0300); push_exp(1, 16'h0100); push_exp(2, 16'h0300);
        run_job("tie_drop", 1'b1, 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog in case a bounded wait is itself stuck.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

endmodule
